// File: rtl/ccg_stim_pkg.sv
// ccg_stim_pkg: shared types and constants for the ccg_stim_gen stimulus source.
//   mode_e  : generator order selector (counter, Galois LFSR, walking-one, reserved)
//   state_e : run-control FSM states
//   Default vector width, LFSR feedback mask and lock-up-free seed.
package ccg_stim_pkg;

  localparam int N_IN_DEFAULT = 21;

  // Taps 21,19 give a maximal-length 21-bit Galois sequence.
  localparam logic [20:0] LFSR_POLY_DEFAULT = 21'h140000;
  localparam logic [20:0] LFSR_SEED_DEFAULT = 21'h000001;

  typedef enum logic [1:0] {
    MODE_CNT  = 2'd0,
    MODE_LFSR = 2'd1,
    MODE_WALK = 2'd2,
    MODE_RSV  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ccg_stim_if.sv
// ccg_stim_if: valid/ready vector stream from ccg_stim_gen to the capture stage.
//   vec_valid : vec_data/vec_last/vec_idx are valid (master -> slave)
//   vec_ready : downstream accepts (slave -> master)
//   vec_data  : N_IN-bit input vector, bit 0 drives x0
//   vec_last  : final vector of the run
//   vec_idx   : index of the current vector, starting at 0
interface ccg_stim_if
  import ccg_stim_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
);
  logic            vec_valid;
  logic            vec_ready;
  logic [N_IN-1:0] vec_data;
  logic            vec_last;
  logic [N_IN:0]   vec_idx;

  modport master (output vec_valid, output vec_data, output vec_last,
                  output vec_idx, input vec_ready);
  modport slave  (input vec_valid, input vec_data, input vec_last,
                  input vec_idx, output vec_ready);
endinterface

// File: rtl/ccg_stim_gen_lfsr.sv
// ccg_lfsr: parameterised Galois LFSR with load, step and zero-seed substitution.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load seed (SEED substituted when seed is zero)
//   seed       : seed value
//   step       : advance one Galois step
//   next_o     : value the register takes at the next edge (state_d)
module ccg_lfsr
  import ccg_stim_pkg::*;
#(
  parameter int          N    = N_IN_DEFAULT,
  parameter logic [N-1:0] POLY = N'(LFSR_POLY_DEFAULT),
  parameter logic [N-1:0] SEED = N'(LFSR_SEED_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         step,
  output logic [N-1:0] next_o
);
  logic [N-1:0] state_q;
  logic [N-1:0] state_d;

  // Next-state: load has priority; a zero seed would lock the register up.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == {N{1'b0}}) ? SEED : seed;
    end else if (step) begin
      state_d = {1'b0, state_q[N-1:1]} ^ (state_q[0] ? POLY : {N{1'b0}});
    end else begin
      state_d = state_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= {N{1'b0}};
    end else begin
      state_q <= state_d;
    end
  end

  // The top registers this value as vec_data, keeping outputs flop-driven.
  assign next_o = state_d;
endmodule

// File: rtl/ccg_stim_gen.sv
// ccg_stim_gen: stimulus source for a combinational benchmark core.
// Emits num_vec vectors in counter, Galois-LFSR or (optional) walking-one order
// over a valid/ready stream, flagging the final vector with vec_last.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, abort      : begin a run (IDLE/DONE only) / terminate a run
//   mode              : 0 counter, 1 LFSR, 2 walking-one, 3 reserved (counter)
//   num_vec, seed_in  : run length (0..2^N_IN), LFSR seed / counter start
//   vec (master)      : vec_valid, vec_ready, vec_data, vec_last, vec_idx
//   busy, done        : high in RUN / high in DONE until the next start
// Optional feature macro: CCG_STIM_WALK_EN enables walking-one/zero mode 2;
// without it mode 2 aliases counter mode and no walk logic exists.
module ccg_stim_gen
  import ccg_stim_pkg::*;
#(
  parameter int            N_IN      = N_IN_DEFAULT,
  parameter logic [N_IN-1:0] LFSR_POLY = N_IN'(LFSR_POLY_DEFAULT),
  parameter logic [N_IN-1:0] LFSR_SEED = N_IN'(LFSR_SEED_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [N_IN:0]     num_vec,
  input  logic [N_IN-1:0]   seed_in,
  ccg_stim_if.master        vec,
  output logic              busy,
  output logic              done
);
  localparam logic [N_IN:0]   ONE_IDX = {{N_IN{1'b0}}, 1'b1};
  localparam logic [N_IN-1:0] ONE_DAT = {{(N_IN-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [N_IN:0]   num_q, num_d;
  logic [N_IN-1:0] data_q, data_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  mode_e           mode_eff_s;
  logic            lfsr_load_s;
  logic            lfsr_step_s;
  logic [N_IN-1:0] lfsr_next_s;
  logic [N_IN-1:0] gen_load_s;
  logic [N_IN-1:0] gen_step_s;
  logic            xfer_s;

`ifdef CCG_STIM_WALK_EN
  localparam int WP_W = $clog2(N_IN);
  logic [WP_W-1:0] walk_pos_q, walk_pos_d;
  logic [N_IN-1:0] walk_rot_s;
  logic            walk_wrap_s;
`endif

  assign xfer_s = valid_q && vec.vec_ready;

  // Resolve the requested mode; unsupported encodings fall back to counter.
  always_comb begin
    mode_eff_s = MODE_CNT;
    case (mode_e'(mode))
      MODE_LFSR: mode_eff_s = MODE_LFSR;
`ifdef CCG_STIM_WALK_EN
      MODE_WALK: mode_eff_s = MODE_WALK;
`endif
      default:   mode_eff_s = MODE_CNT;
    endcase
  end

`ifdef CCG_STIM_WALK_EN
  // Walk: rotate left; inverting at each N_IN-vector boundary alternates
  // between walking-one and walking-zero.
  assign walk_rot_s  = {data_q[N_IN-2:0], data_q[N_IN-1]};
  assign walk_wrap_s = (walk_pos_q == WP_W'(N_IN - 1));
`endif

  // Value loaded into vec_data at run start.
  always_comb begin
    gen_load_s = seed_in;
    case (mode_eff_s)
      MODE_LFSR: gen_load_s = lfsr_next_s;
`ifdef CCG_STIM_WALK_EN
      MODE_WALK: gen_load_s = ONE_DAT;
`endif
      default:   gen_load_s = seed_in;
    endcase
  end

  // Value vec_data takes after a transfer (counter wraps modulo 2^N_IN).
  always_comb begin
    gen_step_s = data_q + ONE_DAT;
    case (mode_q)
      MODE_LFSR: gen_step_s = lfsr_next_s;
`ifdef CCG_STIM_WALK_EN
      MODE_WALK: gen_step_s = walk_wrap_s ? ~walk_rot_s : walk_rot_s;
`endif
      default:   gen_step_s = data_q + ONE_DAT;
    endcase
  end

  // Run-control FSM next state and registered-output next values.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    num_d       = num_q;
    data_d      = data_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    last_d      = last_q;
    busy_d      = busy_q;
    done_d      = done_q;
    lfsr_load_s = 1'b0;
    lfsr_step_s = 1'b0;
`ifdef CCG_STIM_WALK_EN
    walk_pos_d  = walk_pos_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        // abort beats a simultaneous start: no run is launched.
        if (start && !abort) begin
          lfsr_load_s = 1'b1;
          mode_d      = mode_eff_s;
          num_d       = num_vec;
          data_d      = gen_load_s;
          idx_d       = {(N_IN+1){1'b0}};
`ifdef CCG_STIM_WALK_EN
          walk_pos_d  = {WP_W{1'b0}};
`endif
          if (num_vec == {(N_IN+1){1'b0}}) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            valid_d = 1'b1;
            last_d  = (num_vec == ONE_IDX);
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (abort) begin
          // Generator does not step even if a transfer coincides.
          state_d = S_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else if (xfer_s) begin
          if (last_q) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            lfsr_step_s = (mode_q == MODE_LFSR);
            data_d      = gen_step_s;
            idx_d       = idx_q + ONE_IDX;
            last_d      = ((idx_q + ONE_IDX) == (num_q - ONE_IDX));
`ifdef CCG_STIM_WALK_EN
            walk_pos_d  = walk_wrap_s ? {WP_W{1'b0}} : (walk_pos_q + {{(WP_W-1){1'b0}}, 1'b1});
`endif
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_CNT;
      num_q   <= {(N_IN+1){1'b0}};
      data_q  <= {N_IN{1'b0}};
      idx_q   <= {(N_IN+1){1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      num_q   <= num_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef CCG_STIM_WALK_EN
  // Position of the walking bit within the current N_IN-vector pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      walk_pos_q <= {WP_W{1'b0}};
    end else begin
      walk_pos_q <= walk_pos_d;
    end
  end
`endif

  ccg_lfsr #(
    .N    (N_IN),
    .POLY (LFSR_POLY),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (lfsr_load_s),
    .seed   (seed_in),
    .step   (lfsr_step_s),
    .next_o (lfsr_next_s)
  );

  assign vec.vec_valid = valid_q;
  assign vec.vec_data  = data_q;
  assign vec.vec_last  = last_q;
  assign vec.vec_idx   = idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_ccg_stim_gen.sv
// tb_ccg_stim_gen: directed table-driven bench for ccg_stim_gen plus
// hand-written sequences for backpressure, abort, zero-length and reset cases.
module tb_ccg_stim_gen;
  import ccg_stim_pkg::*;
  localparam int N = 21;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [N:0]   num_vec = '0;
  logic [N-1:0] seed_in = '0;
  logic         busy;
  logic         done;

  ccg_stim_if #(.N_IN(N)) vif ();

  ccg_stim_gen #(.N_IN(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .mode    (mode),
    .num_vec (num_vec),
    .seed_in (seed_in),
    .vec     (vif.master),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]         mode;
    logic [N:0]         num;
    logic [N-1:0]       seed;
    logic [3:0][N-1:0]  exp;
  } vec_t;

  vec_t tbl [5];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_entry(input int k, input logic [1:0] m, input logic [N:0] n,
                           input logic [N-1:0] s, input logic [N-1:0] e0,
                           input logic [N-1:0] e1, input logic [N-1:0] e2,
                           input logic [N-1:0] e3);
    tbl[k].mode   = m;
    tbl[k].num    = n;
    tbl[k].seed   = s;
    tbl[k].exp[0] = e0;
    tbl[k].exp[1] = e1;
    tbl[k].exp[2] = e2;
    tbl[k].exp[3] = e3;
  endtask

  // Called at a negedge; issues a one-cycle start pulse.
  task automatic pulse_start(input logic [1:0] m, input logic [N:0] n, input logic [N-1:0] s);
    mode    = m;
    num_vec = n;
    seed_in = s;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic run_entry(input vec_t t, input string nm);
    vif.vec_ready = 1'b1;
    pulse_start(t.mode, t.num, t.seed);
    for (int i = 0; i < int'(t.num); i++) begin
      chk($sformatf("%s_valid%0d", nm, i), {31'd0, vif.vec_valid}, 32'd1);
      chk($sformatf("%s_data%0d", nm, i), {11'd0, vif.vec_data}, {11'd0, t.exp[i]});
      chk($sformatf("%s_idx%0d", nm, i), {10'd0, vif.vec_idx}, i);
      chk($sformatf("%s_last%0d", nm, i), {31'd0, vif.vec_last}, (i == int'(t.num) - 1) ? 32'd1 : 32'd0);
      chk($sformatf("%s_busy%0d", nm, i), {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    chk({nm, "_end_valid"}, {31'd0, vif.vec_valid}, 32'd0);
    chk({nm, "_end_done"}, {31'd0, done}, 32'd1);
    chk({nm, "_end_busy"}, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [N-1:0] walk_exp(input int i);
    logic [N-1:0] one;
    logic [N-1:0] w;
    one = {{(N-1){1'b0}}, 1'b1};
`ifdef CCG_STIM_WALK_EN
    w = one << (i % N);
    return ((i / N) % 2 == 1) ? ~w : w;
`else
    w = N'(i);
    return w + one - one;
`endif
  endfunction

  initial begin
    int e;
    vec_t t;
    vif.vec_ready = 1'b1;

    set_entry(0, 2'd0, 22'd4, 21'h0,      21'h0,      21'h1,      21'h2,      21'h3);
    set_entry(1, 2'd1, 22'd3, 21'h0,      21'h000001, 21'h140000, 21'h0A0000, 21'h0);
    set_entry(2, 2'd0, 22'd3, 21'h1FFFFE, 21'h1FFFFE, 21'h1FFFFF, 21'h000000, 21'h0);
    set_entry(3, 2'd3, 22'd3, 21'h5,      21'h5,      21'h6,      21'h7,      21'h0);
    set_entry(4, 2'd1, 22'd2, 21'h3,      21'h000003, 21'h140001, 21'h0,      21'h0);

    // Reset state
    #12;
    chk("rst_valid", {31'd0, vif.vec_valid}, 32'd0);
    chk("rst_last",  {31'd0, vif.vec_last},  32'd0);
    chk("rst_busy",  {31'd0, busy},          32'd0);
    chk("rst_done",  {31'd0, done},          32'd0);
    chk("rst_data",  {11'd0, vif.vec_data},  32'd0);
    chk("rst_idx",   {10'd0, vif.vec_idx},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      run_entry(tbl[k], $sformatf("tbl%0d", k));
    end

    // Zero-length run: done after one cycle, valid never rises.
    pulse_start(2'd0, 22'd0, 21'h0);
    chk("zero_done",  {31'd0, done},          32'd1);
    chk("zero_valid", {31'd0, vif.vec_valid}, 32'd0);
    chk("zero_busy",  {31'd0, busy},          32'd0);
    @(negedge clk);
    chk("zero_valid2", {31'd0, vif.vec_valid}, 32'd0);

    // Backpressure: ready low for 5 cycles while vector 2 is presented.
    pulse_start(2'd0, 22'd5, 21'h0);
    e = 0;
    for (int c = 0; c < 20 && e < 5; c++) begin
      vif.vec_ready = !(c >= 2 && c < 7);
      chk($sformatf("bp_valid_c%0d", c), {31'd0, vif.vec_valid}, 32'd1);
      chk($sformatf("bp_data_c%0d", c), {11'd0, vif.vec_data}, e);
      chk($sformatf("bp_idx_c%0d", c), {10'd0, vif.vec_idx}, e);
      if (vif.vec_ready) e++;
      @(negedge clk);
    end
    chk("bp_count", e, 32'd5);
    chk("bp_done", {31'd0, done}, 32'd1);
    vif.vec_ready = 1'b1;

    // Abort after two transfers; start during RUN is ignored.
    pulse_start(2'd0, 22'd10, 21'h0);
    chk("ab_data0", {11'd0, vif.vec_data}, 32'd0);
    @(negedge clk);
    chk("ab_data1", {11'd0, vif.vec_data}, 32'd1);
    pulse_start(2'd1, 22'd3, 21'h64);
    chk("ab_data2", {11'd0, vif.vec_data}, 32'd2);
    chk("ab_idx2",  {10'd0, vif.vec_idx},  32'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_valid", {31'd0, vif.vec_valid}, 32'd0);
    chk("ab_last",  {31'd0, vif.vec_last},  32'd0);
    chk("ab_done",  {31'd0, done},          32'd0);
    chk("ab_busy",  {31'd0, busy},          32'd0);
    t = '0;
    t.mode = 2'd0; t.num = 22'd2; t.seed = 21'h0;
    t.exp[0] = 21'h0; t.exp[1] = 21'h1;
    run_entry(t, "restart");

    // start and abort together in IDLE/DONE: no run.
    mode = 2'd0; num_vec = 22'd4; seed_in = 21'h0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_valid", {31'd0, vif.vec_valid}, 32'd0);
    chk("sa_busy",  {31'd0, busy},          32'd0);
    @(negedge clk);
    chk("sa_valid2", {31'd0, vif.vec_valid}, 32'd0);

    // Mode 2: walking-one/zero with the macro, counter otherwise.
    vif.vec_ready = 1'b1;
    pulse_start(2'd2, 22'd23, 21'h0);
    for (int i = 0; i < 23; i++) begin
      chk($sformatf("walk_data%0d", i), {11'd0, vif.vec_data}, {11'd0, walk_exp(i)});
      chk($sformatf("walk_last%0d", i), {31'd0, vif.vec_last}, (i == 22) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    chk("walk_done", {31'd0, done}, 32'd1);

    // Asynchronous reset mid-run.
    pulse_start(2'd0, 22'd10, 21'h5);
    @(negedge clk);
    chk("ar_pre_data", {11'd0, vif.vec_data}, 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, vif.vec_valid}, 32'd0);
    chk("ar_data",  {11'd0, vif.vec_data},  32'd0);
    chk("ar_idx",   {10'd0, vif.vec_idx},   32'd0);
    chk("ar_busy",  {31'd0, busy},          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_valid_after", {31'd0, vif.vec_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
